// File: rtl/pool_window_reorder.sv
// Reorders a row-major pixel stream into 2x2-window order for the max-pooler,
// or forwards it unchanged (1-cycle latency) when pooling is off for the frame.
module pool_window_reorder #(
   parameter int DATA_W = 8,
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     en_mp_i,
   input  logic                     in_valid_i,
   input  logic signed [DATA_W-1:0] in_i,
   output logic                     in_ready_o,
   output logic signed [DATA_W-1:0] out_o,
   output logic                     out_en_o,
   output logic                     frame_done_o,
   output logic [1:0]               dbg_state_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   typedef enum logic [1:0] {
      EVEN  = 2'd0,
      ODD_A = 2'd1,
      ODD_B = 2'd2
   } state_t;

   // Handshake: a pixel transfers on a rising edge where in_valid_i & in_ready_o
   // and clr_i is low; in_ready_o depends only on state, never on in_valid_i.

   state_t                    state_q;
   logic [CW-1:0]             col_q;
   logic [RW-1:0]             row_q;
   logic                      mode_q;
   logic signed [DATA_W-1:0]  out_q;
   logic                      out_en_q;
   logic                      frame_done_q;
   logic signed [DATA_W-1:0]  hold_q;
   logic                      hold_last_col_q;
   logic                      hold_last_frame_q;
   logic signed [DATA_W-1:0]  linebuf_q [WIDTH];

   logic accept;
   logic at_start;
   logic col_last;
   logic row_last;
   logic pool_mode;

   assign in_ready_o = (state_q != ODD_B);
   assign accept     = in_valid_i & in_ready_o & ~clr_i;
   assign at_start   = (col_q == '0) && (row_q == '0);
   assign col_last   = (col_q == COL_LAST);
   assign row_last   = (row_q == ROW_LAST);
   // A pending ODD_B beat of the previous frame still belongs to pool mode even
   // though the counters have already wrapped to (0,0).
   assign pool_mode  = (state_q != EVEN) | (at_start ? en_mp_i : mode_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= EVEN;
         col_q             <= '0;
         row_q             <= '0;
         mode_q            <= 1'b1;
         out_q             <= '0;
         out_en_q          <= 1'b0;
         frame_done_q      <= 1'b0;
         hold_q            <= '0;
         hold_last_col_q   <= 1'b0;
         hold_last_frame_q <= 1'b0;
      end else if (clr_i) begin
         state_q           <= EVEN;
         col_q             <= '0;
         row_q             <= '0;
         mode_q            <= 1'b1;
         out_q             <= '0;
         out_en_q          <= 1'b0;
         frame_done_q      <= 1'b0;
         hold_q            <= '0;
         hold_last_col_q   <= 1'b0;
         hold_last_frame_q <= 1'b0;
      end else begin
         out_en_q     <= 1'b0;
         frame_done_q <= 1'b0;
         if (accept) begin
            if (at_start) mode_q <= en_mp_i;
            if (col_last) begin
               col_q <= '0;
               row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         if (!pool_mode) begin
            if (accept) begin
               out_q        <= in_i;
               out_en_q     <= 1'b1;
               frame_done_q <= col_last & row_last;
            end
         end else begin
            case (state_q)
               EVEN: begin
                  if (accept && col_last) begin
                     state_q      <= row_last ? EVEN : ODD_A;
                     frame_done_q <= row_last;
                  end
               end
               ODD_A: begin
                  if (accept) begin
                     hold_q            <= in_i;
                     out_q             <= linebuf_q[col_q];
                     out_en_q          <= 1'b1;
                     hold_last_col_q   <= col_last;
                     hold_last_frame_q <= col_last & row_last;
                     state_q           <= ODD_B;
                  end
               end
               ODD_B: begin
                  out_q        <= hold_q;
                  out_en_q     <= 1'b1;
                  frame_done_q <= hold_last_frame_q;
                  state_q      <= hold_last_col_q ? EVEN : ODD_A;
               end
               default: state_q <= EVEN;
            endcase
         end
      end
   end

   // Line buffer holds the even row; its contents need no reset.
   always_ff @(posedge clk) begin
      if (accept && pool_mode && (state_q == EVEN)) linebuf_q[col_q] <= in_i;
   end

   assign out_o        = out_q;
   assign out_en_o     = out_en_q;
   assign frame_done_o = frame_done_q;
   assign dbg_state_o  = state_q;

endmodule
